// File: rtl/cordic_job_sched.sv
// cordic_job_sched: arbitrates two requesters onto one shared CORDIC core,
// guards each job with a watchdog and holds the result until it is consumed.
module cordic_job_sched #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] NAN_VALUE      = 32'h7FC00000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   input  logic [31:0] req_theta0,
   input  logic [31:0] req_theta1,
   input  logic [1:0]  req_cos,
   output logic [1:0]  req_ready,
   output logic [1:0]  rsp_valid,
   input  logic [1:0]  rsp_ack,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic [31:0] core_theta,
   output logic        core_start,
   output logic        core_cos,
   input  logic        core_done,
   input  logic [31:0] core_result,
   input  logic        core_invalid,
   output logic        busy,
   output logic [15:0] job_count
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state, state_nxt;
   logic        grant_id;
   logic        job_id;
   logic        last_grant;
   logic        cos_q;
   logic [31:0] theta_q;
   logic [15:0] wd_q;
   logic        wd_expire;
   logic        accept;
   logic        ack_hit;

   assign wd_expire = (wd_q == 16'(TIMEOUT_CYCLES - 1));
   assign accept    = (state == IDLE) && (req_valid != 2'b00);
   assign ack_hit   = (state == RESP) && rsp_ack[job_id];

   assign core_start = (state == BUSY);
   assign busy       = (state != IDLE);
   assign core_theta = theta_q;
   assign core_cos   = cos_q;

   // Round-robin grant: a tie goes to the requester that was not served last.
   always_comb begin
      case (req_valid)
         2'b01:   grant_id = 1'b0;
         2'b10:   grant_id = 1'b1;
         2'b11:   grant_id = ~last_grant;
         default: grant_id = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake outputs.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_nxt = state;
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      case (state)
         IDLE: begin
            if (accept) begin
               req_ready = grant_id ? 2'b10 : 2'b01;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (core_done || wd_expire) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = job_id ? 2'b10 : 2'b01;
            if (rsp_ack[job_id]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Job capture, watchdog, result capture and completion bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         theta_q     <= '0;
         cos_q       <= 1'b0;
         job_id      <= 1'b0;
         last_grant  <= 1'b1;
         wd_q        <= '0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         job_count   <= '0;
      end else begin
         if (accept) begin
            theta_q <= grant_id ? req_theta1 : req_theta0;
            cos_q   <= req_cos[grant_id];
            job_id  <= grant_id;
            wd_q    <= '0;
         end
         if (state == BUSY) begin
            wd_q <= wd_q + 16'd1;
            // A completing core beats a watchdog expiring in the same cycle.
            if (core_done) begin
               rsp_data    <= core_result;
               rsp_err     <= core_invalid;
               rsp_timeout <= 1'b0;
            end else if (wd_expire) begin
               rsp_data    <= NAN_VALUE;
               rsp_err     <= 1'b1;
               rsp_timeout <= 1'b1;
            end
         end
         if (ack_hit) begin
            last_grant <= job_id;
            job_count  <= job_count + 16'd1;
         end
      end
   end

endmodule

// File: doc/cordic_job_sched.md
CORDIC_JOB_SCHED -- requirements
Module: cordic_job_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max BUSY cycles before a job is aborted; 1..65535.
REQ-002 Parameter NAN_VALUE, default 32'h7FC00000, result returned on timeout.
REQ-003 clk  input  1  the single clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  2  per-requester job request; bit i = requester i.
REQ-006 req_theta0, req_theta1  input  32 each  float32 angle of requester 0 / 1.
REQ-007 req_cos  input  2  per-requester op select: 1 = cos, 0 = sin.
REQ-008 req_ready  output  2  one-hot job accept pulse for the granted requester.
REQ-009 rsp_valid  output  2  one-hot, result available for requester i.
REQ-010 rsp_ack  input  2  per-requester result consume.
REQ-011 rsp_data  output  32  float32 result of the current job.
REQ-012 rsp_err  output  1  result invalid: core flagged input invalid, or timeout.
REQ-013 rsp_timeout  output  1  result produced by the watchdog.
REQ-014 core_theta  output  32  angle driven to the shared CORDIC core.
REQ-015 core_start  output  1  core start, held high until core_done.
REQ-016 core_cos  output  1  core op select.
REQ-017 core_done  input  1  core completion pulse.
REQ-018 core_result  input  32  core result, valid with core_done.
REQ-019 core_invalid  input  1  core invalid-input flag, sampled with core_done.
REQ-020 busy  output  1  high in any state other than IDLE.
REQ-021 job_count  output  16  completed jobs, including timeouts; wraps at 16'hFFFF->0.

Function
REQ-022 The FSM SHALL have exactly three states, IDLE, BUSY and RESP, stored in registers.
REQ-023 Grant in IDLE:
- one request valid -> that requester is granted.
- both valid -> the requester not equal to last_grant is granted (round robin).
REQ-024 Accept: in IDLE with any req_valid, req_ready[grant] SHALL be 1 combinationally that cycle; theta, cos and id SHALL be latched; next state BUSY.
REQ-025 req_ready SHALL be 0 in BUSY and RESP, and SHALL never have more than one bit set.
REQ-026 In BUSY:
- core_start = 1; core_theta and core_cos are driven from the latched values, stable for the whole state.
- watchdog counter starts at 0 on BUSY entry and increments each BUSY cycle.
REQ-027 core_done in BUSY SHALL:
- capture core_result into rsp_data;
- set rsp_err = core_invalid and rsp_timeout = 0;
- deassert core_start the following cycle;
- move to RESP.
REQ-028 Watchdog expiry: counter == TIMEOUT_CYCLES-1 without core_done SHALL set rsp_data = NAN_VALUE, rsp_err = 1 and rsp_timeout = 1, then move to RESP.
REQ-029 core_done and watchdog expiry in the same cycle: core_done SHALL win.
REQ-030 core_done outside BUSY SHALL be ignored, with no state or data change.
REQ-031 In RESP:
- rsp_valid[id] = 1; rsp_data, rsp_err and rsp_timeout are held stable.
- rsp_ack[id] = 1 -> IDLE on the next cycle; last_grant <= id; job_count increments.
- rsp_ack on the non-matching bit SHALL be ignored.
REQ-032 A new job SHALL NOT be accepted in the cycle RESP exits; minimum job spacing is BUSY cycles + 2.
REQ-033 rsp_valid SHALL be 0 outside RESP; rsp_data SHALL keep its last value outside RESP.
REQ-034 Requester latency (accept to rsp_valid) SHALL be core latency + 1 cycle.

Reset
REQ-035 On rst_n low, immediately and regardless of clk, including mid-job, the block SHALL set:
- state = IDLE;
- req_ready = 0, rsp_valid = 0, core_start = 0, busy = 0;
- rsp_data = 0, rsp_err = 0, rsp_timeout = 0;
- core_theta = 0, core_cos = 0;
- watchdog = 0, job_count = 0;
- last_grant = 1, so requester 0 wins the first tie.
REQ-036 An in-flight job SHALL be discarded at reset, with no response.
REQ-037 After rst_n deasserts, the first accept SHALL occur no earlier than the first clk edge with rst_n high.

Verification
REQ-038 Single job: req_valid=01, theta0=32'h3F800000, cos=1; core returns 32'h3F0A5140 after 20 cycles -> req_ready=01 for one cycle; core_start high for exactly 20 cycles; rsp_valid=01 with rsp_data=32'h3F0A5140 and rsp_err=0; after ack, job_count=1.
REQ-039 Round robin: both req_valid held for 4 jobs from reset -> grant order 0,1,0,1; never two req_ready bits set together.
REQ-040 Timeout: TIMEOUT_CYCLES=8, core never done -> after 8 BUSY cycles, rsp_data=32'h7FC00000, rsp_err=1, rsp_timeout=1; a late core_done is ignored.
REQ-041 Collision: core_done on the same cycle as watchdog expiry -> rsp_data=core_result and rsp_timeout=0.
REQ-042 Invalid input: core_invalid=1 with core_done -> rsp_err=1, rsp_timeout=0; rsp_ack=10 while id=0 -> stays in RESP until rsp_ack=01.
REQ-043 Reset mid-BUSY: assert rst_n=0 between clk edges -> core_start=0 and busy=0 immediately; after release, a job from requester 0 is accepted normally and job_count counts from 0.
